// File: rtl/if_fetch_stage_pkg.sv
// Shared constants, FSM encoding and IF/ID bundle
// for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] ZERO         = '0;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP      = 32'd4;
    localparam logic [ADDR_WIDTH-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [DATA_WIDTH-1:0] DEF_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic                  valid;
    } if_id_t;

    // Instructions are word aligned; low two address bits are dropped.
    function automatic logic [ADDR_WIDTH-1:0] align_word(
        input logic [ADDR_WIDTH-1:0] a
    );
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Next-PC selection: trap > branch > stall > sequential,
// with word alignment of redirect targets and misalign detect.
module if_pc_gen
    import if_fetch_stage_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  stall_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  trap_i,
    input  logic [ADDR_WIDTH-1:0] trap_target_i,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic                  redirect_o,
    output logic                  misalign_o
);

    logic [ADDR_WIDTH-1:0] target;

    // Pick the redirect target, then the next PC.
    always_comb begin
        target     = ZERO;
        redirect_o = 1'b0;
        next_pc_o  = pc_i + PC_STEP;
        if (trap_i) begin
            target     = trap_target_i;
            redirect_o = 1'b1;
        end else if (branch_i) begin
            target     = branch_target_i;
            redirect_o = 1'b1;
        end
        if (redirect_o) begin
            next_pc_o = align_word(target);
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
        misalign_o = redirect_o && (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, boot FSM,
// IF/ID pipeline register and delivered-instruction counter.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST  = DEF_NOP_INST,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 branch_i,
    input  logic [31:0]          branch_target_i,
    input  logic                 trap_i,
    input  logic [31:0]          trap_target_i,
    output logic                 inst_ce_o,
    output logic [31:0]          pc_o,
    input  logic [31:0]          inst_i,
    output logic [31:0]          id_pc_o,
    output logic [31:0]          id_inst_o,
    output logic                 id_valid_o,
    output logic                 misalign_o,
    output logic [CNT_WIDTH-1:0] fetch_cnt_o
);

    localparam if_id_t BUBBLE = '{pc: ZERO, inst: NOP_INST, valid: 1'b0};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    if_id_t                ifid_q, ifid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  mis_q, mis_d;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  redirect;
    logic                  misalign;

    if_pc_gen u_pc_gen (
        .pc_i            (pc_q),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .trap_i          (trap_i),
        .trap_target_i   (trap_target_i),
        .next_pc_o       (next_pc),
        .redirect_o      (redirect),
        .misalign_o      (misalign)
    );

    // Next state: BOOT holds everything; RUN advances PC and IF/ID.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        unique case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                pc_d  = next_pc;
                mis_d = misalign;
                if (redirect) begin
                    ifid_d = BUBBLE;
                end else if (stall_i) begin
                    ifid_d = ifid_q;
                end else if (flush_i) begin
                    ifid_d = BUBBLE;
                end else begin
                    ifid_d = '{pc: pc_q, inst: inst_i, valid: 1'b1};
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_BOOT;
            pc_q    <= RESET_PC;
            ifid_q  <= BUBBLE;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign inst_ce_o   = (state_q == FETCH_RUN);
    assign pc_o        = pc_q;
    assign id_pc_o     = ifid_q.pc;
    assign id_inst_o   = ifid_q.inst;
    assign id_valid_o  = ifid_q.valid;
    assign misalign_o  = mis_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage
// with a behavioural instruction RAM.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch, trap;
    logic [31:0] btgt, ttgt;
    logic        ce;
    logic [31:0] pc, inst, id_pc, id_inst;
    logic        id_valid, mis;
    logic [31:0] cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // RAM contents: two fixed words, every other address a tagged pattern.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return 32'hA500_0000 ^ a;
    endfunction

    assign inst = ram_word(pc);

    if_fetch_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_i        (branch),
        .branch_target_i (btgt),
        .trap_i          (trap),
        .trap_target_i   (ttgt),
        .inst_ce_o       (ce),
        .pc_o            (pc),
        .inst_i          (inst),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst),
        .id_valid_o      (id_valid),
        .misalign_o      (mis),
        .fetch_cnt_o     (cnt)
    );

    typedef struct {
        logic        rst, stall, flush, branch, trap;
        logic [31:0] btgt, ttgt;
        logic [31:0] e_pc;
        logic        e_ce, e_valid;
        logic [31:0] e_inst, e_idpc;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, s, f, b, t,
                       input logic [31:0] bt, tt, epc,
                       input logic ece, ev,
                       input logic [31:0] ei, eidpc,
                       input logic em,
                       input logic [31:0] ec);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.branch = b; v.trap = t;
        v.btgt = bt; v.ttgt = tt; v.e_pc = epc; v.e_ce = ece;
        v.e_valid = ev; v.e_inst = ei; v.e_idpc = eidpc;
        v.e_mis = em; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, s, f, b, t,
                         input logic [31:0] bt, tt);
        @(negedge clk);
        rst = r; stall = s; flush = f; branch = b; trap = t;
        btgt = bt; ttgt = tt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] mpc, mcnt;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        branch = 1'b0; trap = 1'b0; btgt = '0; ttgt = '0;

        //   r s f b t  btgt          ttgt          pc            ce v  inst                    idpc          m cnt
        add(1,0,0,0,0, 32'h0,        32'h0,        32'h0,        0,0, NOP,                    32'h0,        0,0);
        add(1,0,0,0,0, 32'h0,        32'h0,        32'h0,        0,0, NOP,                    32'h0,        0,0);
        add(0,0,0,0,0, 32'h0,        32'h0,        32'h0,        1,0, NOP,                    32'h0,        0,0);
        add(0,0,0,0,0, 32'h0,        32'h0,        32'h4,        1,1, 32'h0010_0093,          32'h0,        0,1);
        add(0,0,0,0,0, 32'h0,        32'h0,        32'h8,        1,1, 32'h0020_0113,          32'h4,        0,2);
        add(0,1,0,0,0, 32'h0,        32'h0,        32'h8,        1,1, 32'h0020_0113,          32'h4,        0,2);
        add(0,1,0,0,0, 32'h0,        32'h0,        32'h8,        1,1, 32'h0020_0113,          32'h4,        0,2);
        add(0,1,0,0,0, 32'h0,        32'h0,        32'h8,        1,1, 32'h0020_0113,          32'h4,        0,2);
        add(0,0,0,0,0, 32'h0,        32'h0,        32'hC,        1,1, 32'hA500_0008,          32'h8,        0,3);
        add(0,1,0,1,0, 32'h40,       32'h0,        32'h40,       1,0, NOP,                    32'h0,        0,3);
        add(0,0,0,1,1, 32'h40,       32'h80,       32'h80,       1,0, NOP,                    32'h0,        0,3);
        add(0,0,0,0,0, 32'h0,        32'h0,        32'h84,       1,1, 32'hA500_0080,          32'h80,       0,4);
        add(0,0,0,1,0, 32'h42,       32'h0,        32'h40,       1,0, NOP,                    32'h0,        1,4);
        add(0,0,0,0,0, 32'h0,        32'h0,        32'h44,       1,1, 32'hA500_0040,          32'h40,       0,5);
        add(0,0,1,0,0, 32'h0,        32'h0,        32'h48,       1,0, NOP,                    32'h0,        0,5);
        add(0,1,0,0,1, 32'h0,        32'h83,       32'h80,       1,0, NOP,                    32'h0,        1,5);
        add(0,1,1,0,0, 32'h0,        32'h0,        32'h80,       1,0, NOP,                    32'h0,        0,5);
        add(0,0,0,1,0, 32'hFFFF_FFFC,32'h0,        32'hFFFF_FFFC,1,0, NOP,                    32'h0,        0,5);
        add(0,0,0,0,0, 32'h0,        32'h0,        32'h0,        1,1, 32'hA500_0000^32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,6);
        add(0,0,0,1,0, 32'h100,      32'h0,        32'h100,      1,0, NOP,                    32'h0,        0,6);
        add(1,0,0,1,1, 32'h40,       32'h83,       32'h0,        0,0, NOP,                    32'h0,        0,0);
        add(0,1,1,1,0, 32'h42,       32'h0,        32'h0,        1,0, NOP,                    32'h0,        0,0);
        add(0,0,0,0,0, 32'h0,        32'h0,        32'h4,        1,1, 32'h0010_0093,          32'h0,        0,1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush,
                  vecs[i].branch, vecs[i].trap, vecs[i].btgt, vecs[i].ttgt);
            chk($sformatf("v%0d pc", i),    pc,              vecs[i].e_pc);
            chk($sformatf("v%0d ce", i),    {31'b0, ce},     {31'b0, vecs[i].e_ce});
            chk($sformatf("v%0d valid", i), {31'b0, id_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d inst", i),  id_inst,         vecs[i].e_inst);
            chk($sformatf("v%0d idpc", i),  id_pc,           vecs[i].e_idpc);
            chk($sformatf("v%0d mis", i),   {31'b0, mis},    {31'b0, vecs[i].e_mis});
            chk($sformatf("v%0d cnt", i),   cnt,             vecs[i].e_cnt);
        end

        // Straight-line run: each edge delivers the word at the old PC.
        mpc  = 32'h4;
        mcnt = 32'd1;
        for (int k = 0; k < 16; k++) begin
            drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
            chk($sformatf("seq%0d idpc", k), id_pc, mpc);
            chk($sformatf("seq%0d inst", k), id_inst, ram_word(mpc));
            mpc  = mpc + 32'd4;
            mcnt = mcnt + 32'd1;
            chk($sformatf("seq%0d pc", k), pc, mpc);
            chk($sformatf("seq%0d cnt", k), cnt, mcnt);
        end

        // Misaligned branch: pulse must last exactly one cycle.
        drive(0, 0, 0, 1, 0, 32'h203, 32'h0);
        chk("mis pulse on", {31'b0, mis}, 32'd1);
        chk("mis pc", pc, 32'h200);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("mis pulse off", {31'b0, mis}, 32'd0);
        chk("stall after redirect pc", pc, 32'h200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
